// File: rtl/icache_pkg.sv
// Shared CPU cache parameters and FSM state encoding, common to the icache and memory controller.
package icache_pkg;

  localparam int unsigned IC_BLOCK_WIDTH = 1;
  localparam int unsigned IC_CACHE_WIDTH = 8;
  localparam int unsigned IC_BLOCK_BITS  = 32 << IC_BLOCK_WIDTH;
  localparam int unsigned IC_TAG_WIDTH   = 32 - IC_CACHE_WIDTH - IC_BLOCK_WIDTH - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_e;

  function automatic int unsigned ic_tag_width(input int unsigned block_w, input int unsigned cache_w);
    return 32 - cache_w - block_w - 2;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data store: combinational read port, one write port, valid bits cleared on reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned IDX_W  = IC_CACHE_WIDTH,
  parameter int unsigned TAG_W  = IC_TAG_WIDTH,
  parameter int unsigned DATA_W = IC_BLOCK_BITS
) (
  input  logic              Sys_clk,
  input  logic              Sys_rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: an invalid line is never reported as a hit.
  always_ff @(posedge Sys_clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with a single outstanding refill (IDLE/MISS).
// Define ICACHE_PERF_EN to add saturating hit/miss counters ICPERF_hit / ICPERF_miss.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = IC_BLOCK_WIDTH,
  parameter int unsigned CACHE_WIDTH = IC_CACHE_WIDTH
) (
  input  logic                          Sys_clk,
  input  logic                          Sys_rst_n,
  input  logic                          Sys_rdy,
  input  logic                          IFIC_en,
  input  logic [31:0]                   IFIC_addr,
  output logic                          ICIF_en,
  output logic [31:0]                   ICIF_data,
  input  logic                          RoBIC_clear,
  output logic                          ICMC_en,
  output logic [31:0]                   ICMC_addr,
  input  logic                          MCIC_en,
  input  logic [(32<<BLOCK_WIDTH)-1:0]  MCIC_block
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                   ICPERF_hit,
  output logic [31:0]                   ICPERF_miss
`endif
);

  localparam int unsigned OFF_W    = BLOCK_WIDTH + 2;
  localparam int unsigned TAG_W    = ic_tag_width(BLOCK_WIDTH, CACHE_WIDTH);
  localparam int unsigned BLK_BITS = 32 << BLOCK_WIDTH;

  icache_state_e           state;
  logic                    squash;
  logic [BLOCK_WIDTH-1:0]  req_wsel;

  logic                    line_valid;
  logic [TAG_W-1:0]        line_tag;
  logic [BLK_BITS-1:0]     line_data;
  logic                    hit_c;
  logic                    we_c;
  logic [BLOCK_WIDTH-1:0]  fetch_wsel;
  logic                    unused_addr_bits;

  // Memory byte i of a block sits at the top of the bus; words are little-endian.
  function automatic logic [31:0] pick_word(input logic [BLK_BITS-1:0] blk,
                                            input logic [BLOCK_WIDTH-1:0] wsel);
    logic [31:0] word;
    word = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      word[8*b +: 8] = blk[BLK_BITS - 1 - 8*(4*32'(wsel) + b) -: 8];
    end
    return word;
  endfunction

  assign fetch_wsel       = IFIC_addr[2 +: BLOCK_WIDTH];
  assign hit_c            = line_valid && (line_tag == IFIC_addr[31 -: TAG_W]);
  assign we_c             = Sys_rdy && MCIC_en;
  assign unused_addr_bits = ^IFIC_addr[1:0];

  // Refills (including late duplicates) always target the last requested block.
  icache_array #(
    .IDX_W  (CACHE_WIDTH),
    .TAG_W  (TAG_W),
    .DATA_W (BLK_BITS)
  ) u_array (
    .Sys_clk   (Sys_clk),
    .Sys_rst_n (Sys_rst_n),
    .rd_idx    (IFIC_addr[OFF_W +: CACHE_WIDTH]),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .we        (we_c),
    .wr_idx    (ICMC_addr[OFF_W +: CACHE_WIDTH]),
    .wr_tag    (ICMC_addr[31 -: TAG_W]),
    .wr_data   (MCIC_block)
  );

  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      state     <= IDLE;
      squash    <= 1'b0;
      req_wsel  <= '0;
      ICIF_en   <= 1'b0;
      ICIF_data <= '0;
      ICMC_en   <= 1'b0;
      ICMC_addr <= '0;
    end else if (Sys_rdy) begin
      ICIF_en <= 1'b0;
      case (state)
        IDLE: begin
          if (IFIC_en && !RoBIC_clear) begin
            if (hit_c) begin
              ICIF_en   <= 1'b1;
              ICIF_data <= pick_word(line_data, fetch_wsel);
            end else begin
              req_wsel  <= fetch_wsel;
              squash    <= 1'b0;
              ICMC_en   <= 1'b1;
              ICMC_addr <= {IFIC_addr[31:OFF_W], OFF_W'(0)};
              state     <= MISS;
            end
          end
        end
        MISS: begin
          if (RoBIC_clear) begin
            squash <= 1'b1;
          end
          if (MCIC_en) begin
            ICMC_en <= 1'b0;
            squash  <= 1'b0;
            state   <= IDLE;
            if (!squash && !RoBIC_clear) begin
              ICIF_en   <= 1'b1;
              ICIF_data <= pick_word(MCIC_block, req_wsel);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic acc_c;
  assign acc_c = Sys_rdy && (state == IDLE) && IFIC_en && !RoBIC_clear;

  // Saturating counters of accepted, non-flushed lookups.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst_n) begin
      ICPERF_hit  <= '0;
      ICPERF_miss <= '0;
    end else if (acc_c) begin
      if (hit_c && (ICPERF_hit != '1)) begin
        ICPERF_hit <= ICPERF_hit + 32'd1;
      end
      if (!hit_c && (ICPERF_miss != '1)) begin
        ICPERF_miss <= ICPERF_miss + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache: the bench plays the fetch unit and the memory controller.
module tb_icache;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst_n = 1'b0;
  logic        Sys_rdy = 1'b1;
  logic        IFIC_en = 1'b0;
  logic [31:0] IFIC_addr = '0;
  logic        ICIF_en;
  logic [31:0] ICIF_data;
  logic        RoBIC_clear = 1'b0;
  logic        ICMC_en;
  logic [31:0] ICMC_addr;
  logic        MCIC_en = 1'b0;
  logic [63:0] MCIC_block = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] ICPERF_hit;
  logic [31:0] ICPERF_miss;
`endif

  icache dut (
    .Sys_clk     (Sys_clk),
    .Sys_rst_n   (Sys_rst_n),
    .Sys_rdy     (Sys_rdy),
    .IFIC_en     (IFIC_en),
    .IFIC_addr   (IFIC_addr),
    .ICIF_en     (ICIF_en),
    .ICIF_data   (ICIF_data),
    .RoBIC_clear (RoBIC_clear),
    .ICMC_en     (ICMC_en),
    .ICMC_addr   (ICMC_addr),
    .MCIC_en     (MCIC_en),
    .MCIC_block  (MCIC_block)
`ifdef ICACHE_PERF_EN
    ,
    .ICPERF_hit  (ICPERF_hit),
    .ICPERF_miss (ICPERF_miss)
`endif
  );

  always #5 Sys_clk = ~Sys_clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Reference cache: one entry per index.
  bit          mv[256];
  logic [20:0] mt[256];
  logic [63:0] md[256];
  logic [31:0] pend_addr = '0;
  logic [31:0] last_refill_addr = '0;
  bit          pend_squash = 1'b0;
  int unsigned n_hit = 0;
  int unsigned n_miss = 0;

  // Memory byte i of the block is bus byte (7 - i) counting from the LSB.
  function automatic logic [31:0] word_of(input logic [63:0] blk, input int unsigned w);
    logic [31:0] r;
    logic [63:0] byte_v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      byte_v = (blk >> (8 * (7 - (4 * w + k)))) & 64'hFF;
      r = r + (32'(byte_v) << (8 * k));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic drain(input string nm);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: missing response, %0d still queued at %0t", nm, exp_q.size(), $time);
      exp_q.delete();
    end
  endtask

  // Monitor: every ICIF_en pulse must match the oldest expected word.
  always @(negedge Sys_clk) begin
    if (ICIF_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got ICIF_en=1 data %h expected no response at %0t", ICIF_data, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ICIF_data !== e) begin
          errors++;
          $display("FAIL resp_data: got %h expected %h at %0t", ICIF_data, e, $time);
        end
      end
    end
  end

  task automatic model_write(input logic [31:0] a, input logic [63:0] blk);
    mv[a[10:3]] = 1'b1;
    mt[a[10:3]] = a[31:11];
    md[a[10:3]] = blk;
  endtask

  task automatic do_reset();
    Sys_rst_n = 1'b0;
    @(negedge Sys_clk);
    Sys_rst_n = 1'b1;
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
    last_refill_addr = '0;
    n_hit = 0;
    n_miss = 0;
    exp_q.delete();
    chk("rst_icmc_en", 64'(ICMC_en), 64'd0);
    chk("rst_icmc_addr", 64'(ICMC_addr), 64'd0);
    chk("rst_icif_en", 64'(ICIF_en), 64'd0);
    chk("rst_icif_data", 64'(ICIF_data), 64'd0);
  endtask

  task automatic issue(input logic [31:0] a, input bit clr, output bit missed);
    bit hit;
    hit = mv[a[10:3]] && (mt[a[10:3]] == a[31:11]);
    IFIC_en = 1'b1;
    IFIC_addr = a;
    RoBIC_clear = clr;
    if (!clr) begin
      if (hit) begin
        exp_q.push_back(word_of(md[a[10:3]], 32'(a[2])));
        n_hit++;
      end else begin
        n_miss++;
      end
    end
    missed = !clr && !hit;
    if (missed) begin
      pend_addr = a;
      pend_squash = 1'b0;
      last_refill_addr = {a[31:3], 3'b000};
    end
    @(negedge Sys_clk);
    IFIC_en = 1'b0;
    RoBIC_clear = 1'b0;
    chk("icmc_en_after_fetch", 64'(ICMC_en), 64'(missed));
    if (missed) chk("icmc_addr", 64'(ICMC_addr), 64'({a[31:3], 3'b000}));
    else drain("hit_resp");
  endtask

  // Cycles spent in MISS with fetch noise and optional flushes.
  task automatic miss_wait(input int n, input bit force_clr, input int clr_pct);
    bit clr;
    for (int k = 0; k < n; k++) begin
      IFIC_en = 1'($urandom % 2);
      IFIC_addr = $urandom;
      clr = (force_clr && k == 0) || (int'($urandom % 100) < clr_pct);
      RoBIC_clear = clr;
      if (clr) pend_squash = 1'b1;
      @(negedge Sys_clk);
      IFIC_en = 1'b0;
      RoBIC_clear = 1'b0;
      chk("miss_icmc_en", 64'(ICMC_en), 64'd1);
      chk("miss_icmc_addr", 64'(ICMC_addr), 64'({pend_addr[31:3], 3'b000}));
      drain("miss_quiet");
    end
  endtask

  task automatic freeze(input int n);
    Sys_rdy = 1'b0;
    for (int k = 0; k < n; k++) begin
      IFIC_en = 1'($urandom % 2);
      RoBIC_clear = 1'($urandom % 2);
      IFIC_addr = $urandom;
      @(negedge Sys_clk);
      chk("frz_icmc_en", 64'(ICMC_en), 64'd1);
      chk("frz_icmc_addr", 64'(ICMC_addr), 64'({pend_addr[31:3], 3'b000}));
      chk("frz_icif_en", 64'(ICIF_en), 64'd0);
    end
    Sys_rdy = 1'b1;
    IFIC_en = 1'b0;
    RoBIC_clear = 1'b0;
  endtask

  task automatic refill(input logic [63:0] blk, input bit clr_now, input bit in_miss);
    MCIC_en = 1'b1;
    MCIC_block = blk;
    RoBIC_clear = clr_now;
    if (in_miss) begin
      IFIC_en = 1'($urandom % 2);
      IFIC_addr = $urandom;
      if (!pend_squash && !clr_now) exp_q.push_back(word_of(blk, 32'(pend_addr[2])));
    end
    model_write(last_refill_addr, blk);
    @(negedge Sys_clk);
    MCIC_en = 1'b0;
    RoBIC_clear = 1'b0;
    IFIC_en = 1'b0;
    chk("refill_icmc_en", 64'(ICMC_en), 64'd0);
    drain("refill_resp");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit m;
    logic [31:0] a;
    int r;
    do_reset();

    // Cold miss, then hit in the other word of the same block.
    issue(32'h0000_1004, 1'b0, m);
    miss_wait(2, 1'b0, 0);
    refill(64'h1122334455667788, 1'b0, 1'b1);
    issue(32'h0000_1000, 1'b0, m);

    // Conflict on the same index evicts the first tag.
    issue(32'h0000_1800, 1'b0, m);
    refill({$urandom, $urandom}, 1'b0, 1'b1);
    issue(32'h0000_1000, 1'b0, m);
    miss_wait(1, 1'b0, 0);
    refill(64'h1122334455667788, 1'b0, 1'b1);

    // Flush during refill: no response, but the line is still filled.
    issue(32'h0000_2008, 1'b0, m);
    miss_wait(2, 1'b1, 0);
    refill({$urandom, $urandom}, 1'b0, 1'b1);
    issue(32'h0000_2008, 1'b0, m);

    // Duplicate refill in IDLE rewrites the last refilled line silently.
    refill(64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0);
    issue(32'h0000_200C, 1'b0, m);

    // Fetch and flush together: request dropped.
    issue(32'h0000_1000, 1'b1, m);

    // Freeze mid-miss.
    issue(32'h0000_3000, 1'b0, m);
    freeze(5);
    refill({$urandom, $urandom}, 1'b0, 1'b1);

    // Reset mid-miss, then a stray refill lands at address 0.
    issue(32'h0000_4000, 1'b0, m);
    miss_wait(1, 1'b0, 0);
    do_reset();
    refill({$urandom, $urandom}, 1'b0, 1'b0);
    issue(32'h0000_0004, 1'b0, m);
    issue(32'h0000_1000, 1'b0, m);
    refill({$urandom, $urandom}, 1'b0, 1'b1);

    for (int i = 0; i < 250; i++) begin
      a = {(($urandom % 4) == 3) ? 21'h1F_FFFF : 21'($urandom % 3), 5'd0, 3'($urandom % 6), 3'($urandom)};
      r = int'($urandom % 20);
      if (r < 2) begin
        issue(a, 1'b1, m);
      end else if (r == 2) begin
        refill({$urandom, $urandom}, 1'($urandom % 2), 1'b0);
      end else if (r == 3) begin
        RoBIC_clear = 1'b1;
        @(negedge Sys_clk);
        RoBIC_clear = 1'b0;
        drain("idle_clear");
      end else if (r == 4) begin
        @(negedge Sys_clk);
        drain("idle_gap");
      end else begin
        issue(a, 1'b0, m);
        if (m) begin
          miss_wait(int'($urandom_range(0, 3)), 1'b0, 10);
          if ($urandom % 10 == 0) freeze(int'($urandom_range(1, 5)));
          if ($urandom % 40 == 0) begin
            do_reset();
          end else begin
            refill({$urandom, $urandom}, 1'($urandom % 8 == 0), 1'b1);
          end
        end
      end
    end

    @(negedge Sys_clk);
    drain("final");
`ifdef ICACHE_PERF_EN
    chk("perf_hit", 64'(ICPERF_hit), 64'(n_hit));
    chk("perf_miss", 64'(ICPERF_miss), 64'(n_miss));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
